load_store_unit: RTL and testbench



---
 rtl/lsu_pkg.sv | 52 +++++
 rtl/load_align.sv | 32 +++
 rtl/load_store_unit.sv | 164 ++++++++++++++++
 tb/tb_load_store_unit.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV32I
// size/sign encodings and the request-side byte-lane arithmetic.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsuState_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Legal encoding and natural alignment for the requested access.
  function automatic logic accessOk(input logic isStore, input logic [2:0] f3,
                                    input logic [1:0] off);
    logic legal;
    logic aligned;
    if (isStore) legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else         legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                         (f3 == F3_BU) || (f3 == F3_HU);
    case (f3[1:0])
      2'b01:   aligned = (off[0] == 1'b0);
      2'b10:   aligned = (off == 2'b00);
      default: aligned = 1'b1;
    endcase
    return legal && aligned;
  endfunction

  // Byte enables; the unsigned load encodings share the low two bits.
  function automatic logic [3:0] byteEnable(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Store data replicated across every lane the access size can hit.
  function automatic logic [31:0] laneReplicate(input logic [2:0] f3, input logic [31:0] data);
    case (f3[1:0])
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/halfword out of a read word and extends it.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  // Lane select by byte offset, then sign or zero extension by funct3.
  always_comb begin
    case (offset)
      2'd0:    byteLane = rdata[7:0];
      2'd1:    byteLane = rdata[15:8];
      2'd2:    byteLane = rdata[23:16];
      default: byteLane = rdata[31:24];
    endcase
    halfLane = offset[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    value = {{24{byteLane[7]}}, byteLane};
      F3_BU:   value = {24'h0, byteLane};
      F3_H:    value = {{16{halfLane[15]}}, halfLane};
      F3_HU:   value = {16'h0, halfLane};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between execute and a req/ack memory port.
//
// state | meaning
// IDLE  | waiting for start; start is only honoured here
// REQ   | mem_req held with stable attributes until mem_ack
// RESP  | result ready; done/err/RegWrite are registered on leaving this state
//
// Every output is a flop, so done appears the cycle after RESP: a start with an
// immediate ack completes three cycles later, an illegal access two cycles later.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        RegWrite,
  output logic [4:0]  writeReg,
  output logic [31:0] writeData
);

  lsuState_t   state, stateNext;
  logic        isStoreQ, isStoreNext;
  logic [2:0]  funct3Q, funct3Next;
  logic [1:0]  offsetQ, offsetNext;
  logic [4:0]  rdQ, rdNext;
  logic        errQ, errNext;
  logic [31:0] rdataQ, rdataNext;
  logic        busyNext, doneNext, errOutNext, memReqNext, memWeNext, regWriteNext;
  logic [3:0]  memBeNext;
  logic [31:0] memAddrNext, memWdataNext, writeDataNext, loadValue;
  logic [4:0]  writeRegNext;

  load_align uAlign (
    .rdata  (rdataQ),
    .offset (offsetQ),
    .funct3 (funct3Q),
    .value  (loadValue)
  );

  // Next-state and next-output decode; pulses default low, everything else holds.
  always_comb begin
    stateNext     = state;
    isStoreNext   = isStoreQ;
    funct3Next    = funct3Q;
    offsetNext    = offsetQ;
    rdNext        = rdQ;
    errNext       = errQ;
    rdataNext     = rdataQ;
    busyNext      = busy;
    doneNext      = 1'b0;
    errOutNext    = 1'b0;
    memReqNext    = mem_req;
    memWeNext     = mem_we;
    memBeNext     = mem_be;
    memAddrNext   = mem_addr;
    memWdataNext  = mem_wdata;
    regWriteNext  = 1'b0;
    writeRegNext  = writeReg;
    writeDataNext = writeData;
    case (state)
      IDLE: begin
        if (start) begin
          isStoreNext = is_store;
          funct3Next  = funct3;
          offsetNext  = addr[1:0];
          rdNext      = rd;
          busyNext    = 1'b1;
          if (accessOk(is_store, funct3, addr[1:0])) begin
            stateNext    = REQ;
            errNext      = 1'b0;
            memReqNext   = 1'b1;
            memWeNext    = is_store;
            memBeNext    = byteEnable(funct3, addr[1:0]);
            memAddrNext  = {addr[31:2], 2'b00};
            memWdataNext = laneReplicate(funct3, store_data);
          end else begin
            // Bad access never reaches memory; it just reports through RESP.
            stateNext = RESP;
            errNext   = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          stateNext  = RESP;
          memReqNext = 1'b0;
          memWeNext  = 1'b0;
          rdataNext  = mem_rdata;
        end
      end
      RESP: begin
        stateNext  = IDLE;
        busyNext   = 1'b0;
        doneNext   = 1'b1;
        errOutNext = errQ;
        if (!errQ && !isStoreQ && (rdQ != 5'd0)) begin
          regWriteNext  = 1'b1;
          writeRegNext  = rdQ;
          writeDataNext = loadValue;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state     <= IDLE;
      isStoreQ  <= 1'b0;
      funct3Q   <= 3'd0;
      offsetQ   <= 2'd0;
      rdQ       <= 5'd0;
      errQ      <= 1'b0;
      rdataQ    <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'd0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      RegWrite  <= 1'b0;
      writeReg  <= 5'd0;
      writeData <= 32'd0;
    end else begin
      state     <= stateNext;
      isStoreQ  <= isStoreNext;
      funct3Q   <= funct3Next;
      offsetQ   <= offsetNext;
      rdQ       <= rdNext;
      errQ      <= errNext;
      rdataQ    <= rdataNext;
      busy      <= busyNext;
      done      <= doneNext;
      err       <= errOutNext;
      mem_req   <= memReqNext;
      mem_we    <= memWeNext;
      mem_be    <= memBeNext;
      mem_addr  <= memAddrNext;
      mem_wdata <= memWdataNext;
      RegWrite  <= regWriteNext;
      writeReg  <= writeRegNext;
      writeData <= writeDataNext;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// accesses checked against an arithmetic reference model.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic [4:0]  rd = 5'd0;
  logic        busy, done, err, mem_req, mem_we, RegWrite;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, writeData;
  logic [4:0]  writeReg;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;

  load_store_unit dut (
    .CLK(CLK), .RESET_N(RESET_N), .start(start), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data), .rd(rd),
    .busy(busy), .done(done), .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .RegWrite(RegWrite),
    .writeReg(writeReg), .writeData(writeData)
  );

  always #5 CLK = ~CLK;

  int nCompared = 0;
  int nMismatched = 0;

  // Architectural register-file write history expected from the DUT.
  logic [4:0]  modelWriteReg = 5'd0;
  logic [31:0] modelWriteData = 32'd0;

  // Observations collected by runAccess.
  int          obsReqCycles, obsReqRises, obsDoneAt, obsDoneCount, obsRw, obsStray;
  logic        obsWe, obsErr, obsStable;
  logic [3:0]  obsBe;
  logic [31:0] obsAddr, obsWdata, obsWriteData;
  logic [4:0]  obsWriteReg;

  // ---------------- reference model ----------------
  function automatic int sizeOf(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic modelErr(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    logic legal;
    sz = sizeOf(f3);
    if (st) legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    else    legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                    (f3 == 3'b100) || (f3 == 3'b101);
    if (!legal) return 1'b1;
    return (a % sz) != 0;
  endfunction

  function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [31:0] a);
    int m;
    m = ((1 << sizeOf(f3)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] d);
    case (sizeOf(f3))
      1:       return {24'h0, d[7:0]} * 32'h0101_0101;
      2:       return {16'h0, d[15:0]} * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rdat);
    logic [31:0] raw, mask;
    int sz;
    sz  = sizeOf(f3);
    raw = rdat >> (8 * (a % 4));
    if (sz == 4) return raw;
    mask = (32'h1 << (8 * sz)) - 32'h1;
    raw  = raw & mask;
    if (!f3[2] && raw[8 * sz - 1]) raw = raw | ~mask;
    return raw;
  endfunction

  // ---------------- stimulus driver ----------------
  // Issues one start, acks after waitCycles REQ cycles, records what the DUT
  // does until three cycles past done (or a 40-cycle budget). With hammer set
  // it keeps start asserted with random fields while busy.
  task automatic runAccess(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input logic [4:0] r, input int waitCycles,
                           input logic [31:0] rdataIn, input logic hammer);
    logic prevReq;
    @(negedge CLK);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = d; rd = r;
    obsReqCycles = 0; obsReqRises = 0; obsDoneAt = 0; obsDoneCount = 0; obsRw = 0;
    obsStray = 0; obsStable = 1'b1; obsErr = 1'b0; obsWe = 1'b0; obsBe = 4'd0;
    obsAddr = 32'd0; obsWdata = 32'd0; obsWriteReg = 5'd0; obsWriteData = 32'd0;
    prevReq = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge CLK);
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (hammer && busy) begin
        start = 1'b1; is_store = 1'($urandom_range(0, 1)); funct3 = 3'($urandom_range(0, 7));
        addr = $urandom; store_data = $urandom; rd = 5'($urandom_range(0, 31));
      end else begin
        start = 1'b0;
      end
      if (mem_req) begin
        if (!prevReq) obsReqRises++;
        if (obsReqCycles == 0) begin
          obsBe = mem_be; obsWe = mem_we; obsAddr = mem_addr; obsWdata = mem_wdata;
        end else if (mem_be !== obsBe || mem_we !== obsWe || mem_addr !== obsAddr ||
                     mem_wdata !== obsWdata) begin
          obsStable = 1'b0;
        end
        if (obsReqCycles == waitCycles) begin
          mem_ack = 1'b1; mem_rdata = rdataIn;
        end
        obsReqCycles++;
      end
      prevReq = mem_req;
      if ((err || RegWrite) && !done) obsStray++;
      if (RegWrite) begin
        obsRw++; obsWriteReg = writeReg; obsWriteData = writeData;
      end
      if (done) begin
        obsDoneCount++;
        if (obsDoneAt == 0) begin
          obsDoneAt = cyc; obsErr = err;
        end
      end
      if (obsDoneAt != 0 && cyc >= obsDoneAt + 3) break;
    end
    start = 1'b0; mem_ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RESET_N = 1'b0;
    start = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h44; store_data = 32'h1234_5678;
    repeat (2) @(negedge CLK);
    nCompared++;
    if ({busy, done, err, mem_req, mem_we, RegWrite, mem_be} !== 10'd0) begin
      nMismatched++;
      $display("FAIL reset_ctrl: got %b want 0", {busy, done, err, mem_req, mem_we, RegWrite, mem_be});
    end
    nCompared++;
    if ({mem_addr, mem_wdata, writeReg, writeData} !== 101'd0) begin
      nMismatched++;
      $display("FAIL reset_data: addr=%h wdata=%h reg=%0d data=%h want all 0",
               mem_addr, mem_wdata, writeReg, writeData);
    end
    start = 1'b0;
    RESET_N = 1'b1;
    modelWriteReg = 5'd0; modelWriteData = 32'd0;
  endtask

  task automatic test_store_word();
    runAccess(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 5'd9, 2, $urandom, 1'b0);
    nCompared++;
    if ({obsAddr, obsBe, obsWe, obsWdata} !== {32'h10, 4'b1111, 1'b1, 32'hDEAD_BEEF}) begin
      nMismatched++;
      $display("FAIL sw_req: addr=%h be=%b we=%b wdata=%h want 10/1111/1/deadbeef",
               obsAddr, obsBe, obsWe, obsWdata);
    end
    nCompared++;
    if (obsReqCycles !== 3 || obsStable !== 1'b1) begin
      nMismatched++;
      $display("FAIL sw_hold: req_cycles=%0d stable=%b want 3/1", obsReqCycles, obsStable);
    end
    nCompared++;
    if (obsDoneAt !== 5 || obsDoneCount !== 1 || obsErr !== 1'b0 || obsRw !== 0) begin
      nMismatched++;
      $display("FAIL sw_done: done_at=%0d dones=%0d err=%b rw=%0d want 5/1/0/0",
               obsDoneAt, obsDoneCount, obsErr, obsRw);
    end
  endtask

  task automatic test_load_byte();
    runAccess(1'b0, 3'b000, 32'h0000_0013, $urandom, 5'd5, 0, 32'h80FF_1234, 1'b0);
    nCompared++;
    if ({obsBe, obsWe, obsAddr} !== {4'b1000, 1'b0, 32'h10}) begin
      nMismatched++;
      $display("FAIL lb_req: be=%b we=%b addr=%h want 1000/0/10", obsBe, obsWe, obsAddr);
    end
    nCompared++;
    if (obsRw !== 1 || obsWriteReg !== 5'd5 || obsWriteData !== 32'hFFFF_FF80) begin
      nMismatched++;
      $display("FAIL lb_wb: rw=%0d reg=%0d data=%h want 1/5/ffffff80", obsRw, obsWriteReg, obsWriteData);
    end
    nCompared++;
    if (obsDoneAt !== 3 || obsStray !== 0) begin
      nMismatched++;
      $display("FAIL lb_latency: done_at=%0d stray=%0d want 3/0", obsDoneAt, obsStray);
    end
    modelWriteReg = 5'd5; modelWriteData = 32'hFFFF_FF80;
  endtask

  task automatic test_halfword();
    runAccess(1'b0, 3'b101, 32'h0000_0002, $urandom, 5'd7, 1, 32'h8001_0000, 1'b0);
    nCompared++;
    if (obsBe !== 4'b1100 || obsWriteData !== 32'h0000_8001 || obsWriteReg !== 5'd7) begin
      nMismatched++;
      $display("FAIL lhu: be=%b data=%h reg=%0d want 1100/00008001/7", obsBe, obsWriteData, obsWriteReg);
    end
    modelWriteReg = 5'd7; modelWriteData = 32'h0000_8001;
    runAccess(1'b1, 3'b001, 32'h0000_0002, 32'h0000_ABCD, 5'd0, 0, $urandom, 1'b0);
    nCompared++;
    if (obsWdata !== 32'hABCD_ABCD || obsBe !== 4'b1100 || obsWe !== 1'b1) begin
      nMismatched++;
      $display("FAIL sh: wdata=%h be=%b we=%b want abcdabcd/1100/1", obsWdata, obsBe, obsWe);
    end
    nCompared++;
    if (writeReg !== modelWriteReg || writeData !== modelWriteData) begin
      nMismatched++;
      $display("FAIL sh_hold_wb: reg=%0d data=%h want %0d/%h", writeReg, writeData,
               modelWriteReg, modelWriteData);
    end
  endtask

  task automatic test_errors();
    runAccess(1'b0, 3'b010, 32'h0000_0006, $urandom, 5'd3, 0, $urandom, 1'b0);
    nCompared++;
    if (obsReqCycles !== 0 || obsDoneAt !== 2 || obsErr !== 1'b1 || obsRw !== 0) begin
      nMismatched++;
      $display("FAIL lw_misaligned: req=%0d done_at=%0d err=%b rw=%0d want 0/2/1/0",
               obsReqCycles, obsDoneAt, obsErr, obsRw);
    end
    runAccess(1'b0, 3'b011, 32'h0000_0008, $urandom, 5'd3, 0, $urandom, 1'b0);
    nCompared++;
    if (obsReqCycles !== 0 || obsErr !== 1'b1 || obsRw !== 0 || obsStray !== 0) begin
      nMismatched++;
      $display("FAIL f3_011: req=%0d err=%b rw=%0d stray=%0d want 0/1/0/0",
               obsReqCycles, obsErr, obsRw, obsStray);
    end
    nCompared++;
    if (writeReg !== modelWriteReg || writeData !== modelWriteData) begin
      nMismatched++;
      $display("FAIL err_hold_wb: reg=%0d data=%h want %0d/%h", writeReg, writeData,
               modelWriteReg, modelWriteData);
    end
  endtask

  task automatic test_rd_zero();
    runAccess(1'b0, 3'b010, 32'h0000_0020, $urandom, 5'd0, 1, 32'h1357_9BDF, 1'b0);
    nCompared++;
    if (obsReqCycles !== 2 || obsDoneAt !== 4 || obsErr !== 1'b0 || obsRw !== 0) begin
      nMismatched++;
      $display("FAIL lw_rd0: req=%0d done_at=%0d err=%b rw=%0d want 2/4/0/0",
               obsReqCycles, obsDoneAt, obsErr, obsRw);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rdat;
    rdat = $urandom;
    runAccess(1'b0, 3'b010, 32'h0000_0100, $urandom, 5'd3, 1, rdat, 1'b1);
    nCompared++;
    if (obsReqRises !== 1 || obsDoneCount !== 1 || obsReqCycles !== 2) begin
      nMismatched++;
      $display("FAIL busy_ignore: req_rises=%0d dones=%0d req_cycles=%0d want 1/1/2",
               obsReqRises, obsDoneCount, obsReqCycles);
    end
    nCompared++;
    if (obsRw !== 1 || obsWriteReg !== 5'd3 || obsWriteData !== rdat || obsAddr !== 32'h100) begin
      nMismatched++;
      $display("FAIL busy_ignore_wb: rw=%0d reg=%0d data=%h addr=%h want 1/3/%h/100",
               obsRw, obsWriteReg, obsWriteData, obsAddr, rdat);
    end
    modelWriteReg = 5'd3; modelWriteData = rdat;
  endtask

  task automatic test_reset_in_req();
    int activity;
    @(negedge CLK);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40; rd = 5'd4;
    @(negedge CLK);
    start = 1'b0;
    nCompared++;
    if (mem_req !== 1'b1) begin
      nMismatched++;
      $display("FAIL rst_req_pre: mem_req=%b want 1", mem_req);
    end
    RESET_N = 1'b0;
    @(negedge CLK);
    nCompared++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      nMismatched++;
      $display("FAIL rst_req_drop: mem_req=%b busy=%b done=%b want 0/0/0", mem_req, busy, done);
    end
    RESET_N = 1'b1;
    modelWriteReg = 5'd0; modelWriteData = 32'd0;
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge CLK);
    mem_ack = 1'b0;
    activity = 0;
    for (int i = 0; i < 5; i++) begin
      if (done || err || RegWrite || mem_req || busy) activity++;
      @(negedge CLK);
    end
    nCompared++;
    if (activity !== 0 || writeData !== 32'd0 || writeReg !== 5'd0) begin
      nMismatched++;
      $display("FAIL late_ack: activity=%0d reg=%0d data=%h want 0/0/0", activity, writeReg, writeData);
    end
  endtask

  task automatic test_random();
    logic        st, expErr, expRw;
    logic [2:0]  f3;
    logic [31:0] a, d, rdat, expLoad;
    logic [4:0]  r;
    int          w;
    for (int it = 0; it < 80; it++) begin
      st   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      a    = $urandom;
      d    = $urandom;
      rdat = $urandom;
      r    = (it % 6 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      w    = $urandom_range(0, 3);
      runAccess(st, f3, a, d, r, w, rdat, 1'($urandom_range(0, 1)));
      expErr = modelErr(st, f3, a);
      expRw  = !expErr && !st && (r != 5'd0);
      nCompared++;
      if (obsDoneAt !== (expErr ? 2 : w + 3) || obsErr !== expErr || obsDoneCount !== 1 ||
          obsStray !== 0) begin
        nMismatched++;
        $display("FAIL rnd_done[%0d]: done_at=%0d err=%b dones=%0d stray=%0d want %0d/%b/1/0",
                 it, obsDoneAt, obsErr, obsDoneCount, obsStray, expErr ? 2 : w + 3, expErr);
      end
      nCompared++;
      if (obsReqCycles !== (expErr ? 0 : w + 1)) begin
        nMismatched++;
        $display("FAIL rnd_req_cycles[%0d]: got %0d want %0d", it, obsReqCycles, expErr ? 0 : w + 1);
      end
      if (!expErr) begin
        nCompared++;
        if (obsBe !== modelBe(f3, a) || obsWe !== st || obsAddr !== {a[31:2], 2'b00} ||
            obsStable !== 1'b1) begin
          nMismatched++;
          $display("FAIL rnd_req[%0d]: be=%b we=%b addr=%h stable=%b want %b/%b/%h/1",
                   it, obsBe, obsWe, obsAddr, obsStable, modelBe(f3, a), st, {a[31:2], 2'b00});
        end
        if (st) begin
          nCompared++;
          if (obsWdata !== modelWdata(f3, d)) begin
            nMismatched++;
            $display("FAIL rnd_wdata[%0d]: got %h want %h", it, obsWdata, modelWdata(f3, d));
          end
        end
      end
      nCompared++;
      if (obsRw !== (expRw ? 1 : 0)) begin
        nMismatched++;
        $display("FAIL rnd_regwrite[%0d]: got %0d want %0d", it, obsRw, expRw ? 1 : 0);
      end
      if (expRw) begin
        expLoad = modelLoad(f3, a, rdat);
        modelWriteReg = r; modelWriteData = expLoad;
        nCompared++;
        if (obsWriteReg !== r || obsWriteData !== expLoad) begin
          nMismatched++;
          $display("FAIL rnd_load[%0d]: f3=%b a=%h rdata=%h got %0d/%h want %0d/%h",
                   it, f3, a, rdat, obsWriteReg, obsWriteData, r, expLoad);
        end
      end
      nCompared++;
      if (writeReg !== modelWriteReg || writeData !== modelWriteData) begin
        nMismatched++;
        $display("FAIL rnd_hold[%0d]: got %0d/%h want %0d/%h", it, writeReg, writeData,
                 modelWriteReg, modelWriteData);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_halfword();
    test_errors();
    test_rd_zero();
    test_back_to_back();
    test_reset_in_req();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
